// File: rtl/pipe_adder.sv
// Segmented pipelined adder/subtractor: each stage adds one WIDTH/STAGES slice, with stall/flush.
// Define PIPE_ADDER_SAT_EN to add sat_i and clamp signed overflow to the nearest rail.
module pipe_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             sub_i,
`ifdef PIPE_ADDER_SAT_EN
    input  logic             sat_i,
`endif
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             valid_o
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic [WIDTH-1:0]     src2_eff;
    logic [WIDTH-1:0]     a_in   [STAGES];
    logic [WIDTH-1:0]     b_in   [STAGES];
    logic [WIDTH-1:0]     s_in   [STAGES];
    logic                 c_in   [STAGES];
    logic                 v_in   [STAGES];
    logic [SEG:0]         seg_sum[STAGES];
    logic [WIDTH+SEG-1:0] s_cat  [STAGES];
    logic [WIDTH-1:0]     s_raw  [STAGES];
    logic [WIDTH-1:0]     s_d    [STAGES];
    logic [WIDTH-1:0]     a_q    [STAGES];
    logic [WIDTH-1:0]     b_q    [STAGES];
    logic [WIDTH-1:0]     s_q    [STAGES];
    logic                 c_q    [STAGES];
    logic                 v_q    [STAGES];
`ifdef PIPE_ADDER_SAT_EN
    logic                 sat_in [STAGES];
    logic                 sat_q  [STAGES];
`endif
    logic [WIDTH-1:0]     sum_last;
    logic                 a_msb;
    logic                 b_msb;
    logic                 s_msb;
    logic                 ovf_d;
    logic                 ovf_q;

    assign src2_eff = sub_i ? ~src2_i : src2_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign a_in[k] = src1_i;
            assign b_in[k] = src2_eff;
            assign s_in[k] = '0;
            assign c_in[k] = sub_i;
            assign v_in[k] = valid_i;
`ifdef PIPE_ADDER_SAT_EN
            assign sat_in[k] = sat_i;
`endif
        end else begin : g_src
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign s_in[k] = s_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign v_in[k] = v_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
            assign sat_in[k] = sat_q[k-1];
`endif
        end

        assign seg_sum[k] = {1'b0, a_in[k][SEG-1:0]} + {1'b0, b_in[k][SEG-1:0]}
                          + {{SEG{1'b0}}, c_in[k]};
        // Operands shift down and finished slices shift in from the top, so the full sum
        // lands in place after the last stage.
        assign s_cat[k] = {seg_sum[k][SEG-1:0], s_in[k]};
        assign s_raw[k] = s_cat[k][WIDTH+SEG-1:SEG];

        if (k == LAST) begin : g_res
            assign s_d[k] = sum_last;
        end else begin : g_res
            assign s_d[k] = s_raw[k];
        end

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
`ifdef PIPE_ADDER_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end else if (flush_i) begin
                v_q[k] <= 1'b0;
            end else if (!stall_i) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    c_q[k] <= seg_sum[k][SEG];
                    a_q[k] <= a_in[k] >> SEG;
                    b_q[k] <= b_in[k] >> SEG;
                    s_q[k] <= s_d[k];
`ifdef PIPE_ADDER_SAT_EN
                    sat_q[k] <= sat_in[k];
`endif
                end
            end
        end
    end

    assign a_msb = a_in[LAST][SEG-1];
    assign b_msb = b_in[LAST][SEG-1];
    assign s_msb = s_raw[LAST][WIDTH-1];

    always_comb begin
        ovf_d    = (a_msb == b_msb) && (s_msb != a_msb);
        sum_last = s_raw[LAST];
`ifdef PIPE_ADDER_SAT_EN
        // Overflow only happens with equal operand signs, so a_msb gives the direction.
        if (sat_in[LAST] && ovf_d) begin
            sum_last = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
        end else if (!flush_i && !stall_i && v_in[LAST]) begin
            ovf_q <= ovf_d;
        end
    end

    assign sum_o   = s_q[LAST];
    assign carry_o = c_q[LAST];
    assign ovf_o   = ovf_q;
    assign valid_o = v_q[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: STAGES=2 and STAGES=4 instances share stimulus and are checked every
// cycle against an arithmetic latency-queue model, plus directed vectors and corner sequences.
module tb_pipe_adder;
    localparam int unsigned W = 32;
`ifdef PIPE_ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, valid, sub, sat, stall, flush;
    logic [W-1:0] src1, src2;
    logic [W-1:0] sum2, sum4;
    logic         c2, o2, v2, c4, o4, v4;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        int           rem;
    } ent_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] sum;
        logic         c;
        logic         o;
    } vec_t;

    ent_t         mq[2][$];
    logic         exp_v[2];
    logic [W-1:0] exp_s[2];
    logic         exp_c[2];
    logic         exp_o[2];
    int           n_chk = 0;
    int           n_fail = 0;
    bit           last_stall = 1'b0;
    bit           collect = 1'b0;
    logic [W-1:0] got[$];
    vec_t         vt[10];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .src1_i(src1), .src2_i(src2),
        .sub_i(sub),
`ifdef PIPE_ADDER_SAT_EN
        .sat_i(sat),
`endif
        .stall_i(stall), .flush_i(flush), .sum_o(sum2), .carry_o(c2), .ovf_o(o2),
        .valid_o(v2)
    );

    pipe_adder #(.WIDTH(W), .STAGES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .src1_i(src1), .src2_i(src2),
        .sub_i(sub),
`ifdef PIPE_ADDER_SAT_EN
        .sat_i(sat),
`endif
        .stall_i(stall), .flush_i(flush), .sum_o(sum4), .carry_o(c4), .ovf_o(o4),
        .valid_o(v4)
    );

    // Reference result from true signed / unsigned arithmetic.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic st, output logic [W-1:0] r,
                                   output logic c, output logic o);
        longint sa, sb, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = s ? sa - sb : sa + sb;
        o   = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        c   = s ? (a >= b) : ((longint'(a) + longint'(b)) > 64'sd4294967295);
        r   = res[W-1:0];
        if (st && o) r = (res > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endfunction

    function automatic void model_step(input int i);
        ent_t e;
        int   l;
        l = (i == 0) ? 2 : 4;
        if (!rst_n) begin
            mq[i].delete();
            exp_v[i] = 1'b0;
            exp_s[i] = '0;
            exp_c[i] = 1'b0;
            exp_o[i] = 1'b0;
        end else if (flush) begin
            mq[i].delete();
            exp_v[i] = 1'b0;
        end else if (!stall) begin
            exp_v[i] = 1'b0;
            for (int j = 0; j < mq[i].size(); j++) mq[i][j].rem = mq[i][j].rem - 1;
            if (mq[i].size() != 0 && mq[i][0].rem == 0) begin
                e = mq[i].pop_front();
                exp_v[i] = 1'b1;
                exp_s[i] = e.sum;
                exp_c[i] = e.c;
                exp_o[i] = e.o;
            end
            if (valid) begin
                ref_op(src1, src2, sub, sat & SAT_BUILD, e.sum, e.c, e.o);
                e.rem = l - 1;
                mq[i].push_back(e);
            end
        end
    endfunction

    function automatic void check_inst(input int i, input string nm, input logic v,
                                       input logic [W-1:0] s, input logic c, input logic o);
        n_chk++;
        if (v !== exp_v[i] || s !== exp_s[i] || c !== exp_c[i] || o !== exp_o[i]) begin
            n_fail++;
            $display("FAIL %s: got v=%0b sum=%h c=%0b o=%0b, want v=%0b sum=%h c=%0b o=%0b",
                     nm, v, s, c, o, exp_v[i], exp_s[i], exp_c[i], exp_o[i]);
        end
    endfunction

    // Packed as {valid, carry, ovf, sum}.
    function automatic void check_val(input string nm, input logic [W+2:0] g,
                                      input logic [W+2:0] w);
        n_chk++;
        if (g !== w) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, g, w);
        end
    endfunction

    function automatic void check_int(input string nm, input longint g, input longint w);
        n_chk++;
        if (g != w) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, g, w);
        end
    endfunction

    task automatic cycle();
        @(posedge clk);
        last_stall = stall;
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_inst(0, "model_s2", v2, sum2, c2, o2);
        check_inst(1, "model_s4", v4, sum4, c4, o4);
        if (collect && v2 && !last_stall) got.push_back(sum2);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vt[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vt[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vt[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
        vt[9] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

        rst_n = 1'b0; valid = 1'b0; sub = 1'b0; sat = 1'b0; stall = 1'b0; flush = 1'b0;
        src1 = '0; src2 = '0;
        cycle();
        cycle();
        check_val("reset_s2", {v2, c2, o2, sum2}, '0);
        check_val("reset_s4", {v4, c4, o4, sum4}, '0);
        rst_n = 1'b1;
        cycle();

        for (int k = 0; k < 10; k++) begin
            src1 = vt[k].a; src2 = vt[k].b; sub = vt[k].s; valid = 1'b1;
            cycle();
            valid = 1'b0;
            cycle();
            check_val($sformatf("vec%0d_s2", k), {v2, c2, o2, sum2},
                      {1'b1, vt[k].c, vt[k].o, vt[k].sum});
            cycle();
            cycle();
            check_val($sformatf("vec%0d_s4", k), {v4, c4, o4, sum4},
                      {1'b1, vt[k].c, vt[k].o, vt[k].sum});
        end

`ifdef PIPE_ADDER_SAT_EN
        src1 = 32'h7FFF_FFFF; src2 = 32'h1; sub = 1'b0; sat = 1'b1; valid = 1'b1;
        cycle();
        valid = 1'b0; sat = 1'b0;
        cycle();
        check_val("sat_pos_s2", {v2, c2, o2, sum2}, {1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF});
        cycle();
        cycle();
`endif

        // Eight back-to-back ops with a three-cycle stall after op 2.
        collect = 1'b1;
        sub = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src1 = W'(i); src2 = 32'h10; valid = 1'b1;
            cycle();
            if (i == 2) begin
                check_val("pre_stall_s2", {v2, c2, o2, sum2}, {3'b100, 32'h11});
                src1 = 32'd3; stall = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    cycle();
                    check_val($sformatf("stall_hold%0d", j), {v2, c2, o2, sum2},
                              {3'b100, 32'h11});
                end
                stall = 1'b0;
            end
        end
        valid = 1'b0;
        repeat (5) cycle();
        collect = 1'b0;
        check_int("stall_count", got.size(), 8);
        for (int i = 0; i < got.size() && i < 8; i++) begin
            check_int($sformatf("stall_res%0d", i), got[i], 32'h10 + i);
        end

        // Two ops in flight in the 4-stage pipe, flushed under stall.
        src1 = 32'h1111_1111; src2 = 32'h2222_2222; sub = 1'b0; valid = 1'b1;
        cycle();
        src1 = 32'h3333_3333;
        cycle();
        stall = 1'b1; flush = 1'b1;
        cycle();
        stall = 1'b0; flush = 1'b0;
        src1 = 32'h0000_0100; src2 = 32'h0000_0001; sub = 1'b1;
        cycle();
        valid = 1'b0;
        check_val("flush_j0_s4", {v4, 34'd0}, '0);
        for (int j = 1; j <= 5; j++) begin
            cycle();
            if (j == 3) check_val("flush_c_s4", {v4, c4, o4, sum4}, {3'b110, 32'hFF});
            else check_val($sformatf("flush_j%0d_s4", j), {v4, 34'd0}, '0);
        end

        // Reset mid-stream.
        for (int n = 0; n < 6; n++) begin
            valid = 1'b1; sub = 1'($urandom_range(1)); src1 = pick(); src2 = pick();
            cycle();
        end
        rst_n = 1'b0;
        #1;
        check_val("midrst_s2", {v2, c2, o2, sum2}, '0);
        check_val("midrst_s4", {v4, c4, o4, sum4}, '0);
        valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cycle();
            check_val($sformatf("post_rst%0d_s4", j), {v4, 34'd0}, '0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            valid = ($urandom_range(9) < 8);
            sub   = 1'($urandom_range(1));
            sat   = 1'($urandom_range(1));
            stall = ($urandom_range(7) == 0);
            flush = ($urandom_range(15) == 0);
            src1  = pick();
            src2  = pick();
            cycle();
        end
        valid = 1'b0; stall = 1'b0; flush = 1'b0;
        repeat (5) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
